// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: state encoding and default widths.
package pipe_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefCntW  = 16;

    // Encoding matches the held-entry count so occupancy is the state itself.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } stage_state_e;

    function automatic logic [1:0] occ_of(stage_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between pipeline stages. in_ready is registered so the
// downstream stall never ripples combinationally into the upstream stage.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W = DefDataW,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int unsigned       CNT_W  = DefCntW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  xfer_cnt
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              in_ready_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept, emit;

    assign accept = in_valid && in_ready_q;
    assign emit   = (state_q != StEmpty) && out_ready;

    // Next-state decode; flush overrides any handshake on the same edge.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: if (accept) state_d = StOne;
                StOne: begin
                    if (accept && !emit)      state_d = StFull;
                    else if (!accept && emit) state_d = StEmpty;
                end
                StFull:  if (emit) state_d = StOne;
                default: state_d = StEmpty;
            endcase
        end
    end

    // State, payload registers, registered ready and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StFull);
            if (flush) begin
                main_q <= BUBBLE;
                skid_q <= BUBBLE;
            end else begin
                case (state_q)
                    StEmpty: if (accept) main_q <= in_data;
                    StOne: begin
                        if (accept && !emit) begin
                            skid_q <= in_data;
                        end else if (!accept && emit) begin
                            main_q <= BUBBLE;
                        end else if (accept && emit) begin
                            main_q <= in_data;
                        end
                    end
                    StFull: begin
                        if (emit) begin
                            main_q <= skid_q;
                            skid_q <= BUBBLE;
                        end
                    end
                    default: begin
                        main_q <= BUBBLE;
                        skid_q <= BUBBLE;
                    end
                endcase
                if (emit) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench with a FIFO scoreboard; a second instance with a 4-bit
// counter shares the stimulus to exercise counter wrap.
module tb_pipe_skid_stage;

    localparam logic [31:0] Bubble = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_cnt;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(32), .BUBBLE(Bubble), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_data(in_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .occupancy(a_occ),
        .xfer_cnt(a_cnt)
    );

    pipe_skid_stage #(.DATA_W(32), .BUBBLE(Bubble), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_data(in_data), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data), .occupancy(b_occ),
        .xfer_cnt(b_cnt)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] sb_q[$];
    logic [15:0] exp_cnt;
    logic [3:0]  exp_cnt4;
    logic        live;
    logic        stall_prev;
    logic [31:0] prev_data;
    logic        acc_seen;

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard check at the falling edge, then record the handshakes that
    // the coming rising edge will perform.
    task automatic check();
        logic [31:0] front;
        if (!rst_n) begin
            expect_eq("rst_in_ready", {63'd0, a_in_ready}, 64'd0);
            expect_eq("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
            expect_eq("rst_out_data", {32'd0, a_out_data}, {32'd0, Bubble});
            expect_eq("rst_occ", {62'd0, a_occ}, 64'd0);
            expect_eq("rst_cnt", {48'd0, a_cnt}, 64'd0);
            expect_eq("rst_cnt4", {60'd0, b_cnt}, 64'd0);
            sb_q.delete();
            exp_cnt    = '0;
            exp_cnt4   = '0;
            live       = 1'b0;
            stall_prev = 1'b0;
            acc_seen   = 1'b0;
            return;
        end
        front = (sb_q.size() != 0) ? sb_q[0] : Bubble;
        expect_eq("occ", {62'd0, a_occ}, 64'(sb_q.size()));
        expect_eq("occ_b", {62'd0, b_occ}, 64'(sb_q.size()));
        expect_eq("out_valid", {63'd0, a_out_valid}, {63'd0, sb_q.size() != 0});
        expect_eq("out_valid_b", {63'd0, b_out_valid}, {63'd0, sb_q.size() != 0});
        expect_eq("in_ready", {63'd0, a_in_ready}, {63'd0, live && sb_q.size() != 2});
        expect_eq("in_ready_b", {63'd0, b_in_ready}, {63'd0, live && sb_q.size() != 2});
        expect_eq("out_data", {32'd0, a_out_data}, {32'd0, front});
        expect_eq("out_data_b", {32'd0, b_out_data}, {32'd0, front});
        expect_eq("xfer_cnt", {48'd0, a_cnt}, {48'd0, exp_cnt});
        expect_eq("xfer_cnt_b", {60'd0, b_cnt}, {60'd0, exp_cnt4});
        if (stall_prev) expect_eq("stall_hold", {32'd0, a_out_data}, {32'd0, prev_data});

        acc_seen = 1'b0;
        if (flush) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (a_out_valid && out_ready) begin
                expect_eq("emit_data", {32'd0, a_out_data}, {32'd0, sb_q.pop_front()});
                exp_cnt  = exp_cnt + 16'd1;
                exp_cnt4 = exp_cnt4 + 4'd1;
            end
            if (in_valid && a_in_ready) begin
                sb_q.push_back(in_data);
                acc_seen = 1'b1;
            end
            stall_prev = a_out_valid && !out_ready;
            prev_data  = a_out_data;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check();
        @(posedge clk);
        live = rst_n;
        #1;
    endtask

    // Hold a word on the input until accepted (bounded).
    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (acc_seen) return;
        end
        expect_eq("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        live = 1'b0; stall_prev = 1'b0; prev_data = '0; acc_seen = 1'b0;
        exp_cnt = '0; exp_cnt4 = '0;
        #1;
        do_reset();

        // Single word latency; no accept on first edge after reset release.
        in_valid = 1'b1; in_data = 32'h0000_00AA; out_ready = 1'b1;
        cyc();
        expect_eq("ready_after_rst", {63'd0, a_in_ready}, 64'd1);
        send(32'h0000_00AA);
        in_valid = 1'b0;
        expect_eq("lat_valid", {63'd0, a_out_valid}, 64'd1);
        expect_eq("lat_data", {32'd0, a_out_data}, 64'hAA);
        cyc();
        expect_eq("lat_cnt", {48'd0, a_cnt}, 64'd1);

        // Stall fills both entries; third word waits upstream.
        out_ready = 1'b0;
        send(32'h11);
        expect_eq("stall_occ1", {62'd0, a_occ}, 64'd1);
        send(32'h22);
        expect_eq("stall_occ2", {62'd0, a_occ}, 64'd2);
        expect_eq("stall_ready", {63'd0, a_in_ready}, 64'd0);
        in_data = 32'h33;
        cyc();
        cyc();
        expect_eq("stall_hold_occ", {62'd0, a_occ}, 64'd2);
        out_ready = 1'b1;
        send(32'h33);
        in_valid = 1'b0;
        repeat (4) cyc();
        expect_eq("drain_occ", {62'd0, a_occ}, 64'd0);
        expect_eq("drain_cnt", {48'd0, a_cnt}, 64'd4);

        // Stream 100 words back to back.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(32'h100 + 32'(i));
            expect_eq("stream_occ", {62'd0, a_occ}, 64'd1);
            expect_eq("stream_cnt", {48'd0, a_cnt}, 64'(i));
        end
        in_valid = 1'b0;
        cyc();
        expect_eq("stream_total", {48'd0, a_cnt}, 64'd100);
        expect_eq("stream_total_b", {60'd0, b_cnt}, 64'd4);

        // 17 emits from reset wrap the 4-bit counter to 1.
        do_reset();
        for (int i = 0; i < 17; i++) send(32'h200 + 32'(i));
        in_valid = 1'b0;
        repeat (2) cyc();
        expect_eq("wrap_cnt4", {60'd0, b_cnt}, 64'd1);
        expect_eq("wrap_cnt16", {48'd0, a_cnt}, 64'd17);

        // Flush while full, with a handshake attempted on the same edge.
        out_ready = 1'b0;
        send(32'h44);
        send(32'h55);
        expect_eq("pre_flush_occ", {62'd0, a_occ}, 64'd2);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h66; out_ready = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        expect_eq("flush_occ", {62'd0, a_occ}, 64'd0);
        expect_eq("flush_valid", {63'd0, a_out_valid}, 64'd0);
        expect_eq("flush_data", {32'd0, a_out_data}, {32'd0, Bubble});
        expect_eq("flush_ready", {63'd0, a_in_ready}, 64'd1);
        expect_eq("flush_cnt", {48'd0, a_cnt}, 64'd17);
        cyc();

        // Asynchronous reset while full clears outputs before any clock edge.
        out_ready = 1'b0;
        send(32'h77);
        send(32'h88);
        expect_eq("pre_arst_occ", {62'd0, a_occ}, 64'd2);
        #2 rst_n = 1'b0;
        #1;
        expect_eq("arst_valid", {63'd0, a_out_valid}, 64'd0);
        expect_eq("arst_occ", {62'd0, a_occ}, 64'd0);
        expect_eq("arst_data", {32'd0, a_out_data}, {32'd0, Bubble});
        cyc();
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
        cyc();
        expect_eq("arst_ready_first", {63'd0, a_in_ready}, 64'd1);
        send(32'h99);
        in_valid = 1'b0;
        repeat (2) cyc();
        expect_eq("arst_cnt", {48'd0, a_cnt}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the stage payload.
REQ-002 Parameter BUBBLE, default 0, DATA_W-bit value driven on out_data when the stage is empty or flushed.
REQ-003 Parameter CNT_W, default 16, width of the transfer counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage can accept; registered output.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  downstream payload valid.
REQ-011 out_ready  input  1  downstream can accept (low = stall).
REQ-012 out_data  output  DATA_W  downstream payload.
REQ-013 occupancy  output  2  number of held entries, 0..2.
REQ-014 xfer_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-015 An accept SHALL occur on an edge where in_valid=1 and in_ready=1; an emit SHALL occur where out_valid=1 and out_ready=1.
REQ-016 Storage SHALL be two entries: a main register (drives out_data) and a skid register.
REQ-017 FSM states SHALL be EMPTY (0 entries), ONE (main valid), FULL (main and skid valid); occupancy SHALL equal 0/1/2 respectively.
REQ-018 EMPTY: accept -> ONE, main<=in_data.
REQ-019 ONE: accept only -> FULL, skid<=in_data; emit only -> EMPTY; accept and emit together -> ONE, main<=in_data.
REQ-020 FULL: emit -> ONE, main<=skid; no accept is possible in FULL.
REQ-021 in_ready SHALL be registered, equal to (next state != FULL); no combinational path from out_ready to in_ready.
REQ-022 out_valid SHALL be 1 exactly in ONE and FULL; latency from accept in EMPTY to out_valid=1 SHALL be one cycle.
REQ-023 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 out_data SHALL equal BUBBLE whenever state is EMPTY.
REQ-025 Ordering SHALL be strictly FIFO; no payload duplicated or dropped except by flush.
REQ-026 flush=1 SHALL have highest priority: next state EMPTY, out_data<=BUBBLE, in_ready<=1, and any accept or emit on that edge is discarded (xfer_cnt not incremented).
REQ-027 xfer_cnt SHALL increment by 1 per emit, modulo 2^CNT_W (wraps from all-ones to 0).
REQ-028 in_valid while in_ready=0 SHALL have no effect; upstream holds its data.

Reset
REQ-029 While rst_n=0: state EMPTY, out_valid=0, in_ready=0, out_data=BUBBLE, occupancy=0, xfer_cnt=0, both registers cleared to BUBBLE.
REQ-030 First rising edge after rst_n release SHALL set in_ready=1; no accept occurs on that edge.
REQ-031 Reset asserted mid-transfer SHALL discard all held entries immediately, without waiting for clk.

Structure
REQ-032 State encoding (EMPTY, ONE, FULL) and default DATA_W/CNT_W constants SHALL live in shared package pipe_pkg.
REQ-033 Block SHALL be a single module; no sub-module required; instantiable as drop-in replacement for each existing inter-stage buffer (IF/ID, ID/EX, EX/MEM, MEM/WB) by setting DATA_W to the concatenated field width.

Verification
REQ-034 Reset then in_valid=1, in_data=0x0000_00AA, out_ready=1 -> out_valid=1, out_data=0xAA one cycle after accept; xfer_cnt=1 after emit.
REQ-035 out_ready=0, push 0x11, 0x22, 0x33 on consecutive cycles -> occupancy 1 then 2, in_ready=0 after second accept, 0x33 held upstream; release out_ready -> outputs 0x11, 0x22, 0x33 in order.
REQ-036 Streaming 100 words with out_ready=1 continuously -> one emit per cycle after the first, occupancy stays 1, xfer_cnt=100.
REQ-037 FULL with 0x44/0x55, assert flush with in_valid=1 and out_ready=1 -> next cycle state EMPTY, out_valid=0, out_data=BUBBLE, in_ready=1, xfer_cnt unchanged.
REQ-038 CNT_W=4, perform 17 emits -> xfer_cnt=1 (wrap).
REQ-039 rst_n low between edges while FULL -> out_valid=0 and occupancy=0 immediately; after release, in_ready=1 from first edge.
